// File: rtl/game_pkg.sv
// Shared game-logic types: game state codes, block index width
// and the block scan scheduler state encoding.
package game_pkg;

    localparam int IDX_W = 8;

    typedef enum logic [1:0] {
        GS_MENU    = 2'd0,
        GS_PLAYING = 2'd1,
        GS_PAUSED  = 2'd2,
        GS_OVER    = 2'd3
    } game_state_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_COMMIT = 3'd3,
        ST_DONE   = 3'd4
    } sched_state_t;

endpackage

// File: rtl/visible_slot_table.sv
// Slot table of visible block indices: one write port from the
// scan scheduler, one combinational read port for the renderer.
module visible_slot_table
    import game_pkg::*;
#(
    parameter int MAX_VISIBLE = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             we_in,
    input  logic [3:0]       waddr_in,
    input  logic [IDX_W-1:0] wdata_in,
    input  logic [3:0]       raddr_in,
    output logic [IDX_W-1:0] rdata_out
);

    logic [IDX_W-1:0] slot_q [MAX_VISIBLE];
    logic [IDX_W-1:0] slot_d [MAX_VISIBLE];

    always_comb begin
        for (int i = 0; i < MAX_VISIBLE; i++) begin
            slot_d[i] = slot_q[i];
            if (we_in && (waddr_in == 4'(i))) begin
                slot_d[i] = wdata_in;
            end
        end
    end

    // Out-of-range read addresses return zero
    always_comb begin
        rdata_out = '0;
        for (int i = 0; i < MAX_VISIBLE; i++) begin
            if (raddr_in == 4'(i)) begin
                rdata_out = slot_q[i];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < MAX_VISIBLE; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MAX_VISIBLE; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

endmodule

// File: rtl/block_scan_scheduler.sv
// Per-frame block scan: walks block indices through the position
// lookup and compacts visible ones into the slot table.
module block_scan_scheduler
    import game_pkg::*;
#(
    parameter int NUM_BLOCKS  = 6,
    parameter int MAX_VISIBLE = 4,
    parameter int TIMEOUT     = 15
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             new_frame_in,
    input  logic [1:0]       game_state_in,
    output logic [IDX_W-1:0] idx_out,
    output logic             idx_valid_out,
    input  logic             pos_ready_in,
    input  logic             pos_visible_in,
    output logic             slot_we_out,
    output logic [3:0]       slot_addr_out,
    output logic [IDX_W-1:0] slot_index_out,
    output logic [4:0]       visible_count_out,
    output logic             scan_busy_out,
    output logic             scan_done_out,
    output logic             overflow_out,
    output logic [7:0]       timeout_count_out,
    output logic             aborted_out
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);
    localparam logic [4:0]       MAX_VIS  = 5'(MAX_VISIBLE);
    localparam logic [7:0]       TO_LIM   = 8'(TIMEOUT);

    sched_state_t     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [4:0]       vcount_q, vcount_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       wait_q, wait_d;
    logic [7:0]       tcount_q, tcount_d;
    logic             abort_q, abort_d;

    logic playing;
    logic advance;
    logic abort;

    assign playing = (game_state_in == GS_PLAYING);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        vcount_d = vcount_q;
        ovf_d    = ovf_q;
        wait_d   = wait_q;
        tcount_d = tcount_q;
        abort_d  = 1'b0;
        advance  = 1'b0;
        abort    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (new_frame_in && playing) begin
                    state_d  = ST_ISSUE;
                    idx_d    = '0;
                    vcount_d = '0;
                    ovf_d    = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (!playing) begin
                    abort = 1'b1;
                end else begin
                    wait_d  = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!playing) begin
                    abort = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                    if (pos_ready_in && pos_visible_in && (vcount_q < MAX_VIS)) begin
                        state_d = ST_COMMIT;
                    end else if (pos_ready_in && pos_visible_in) begin
                        ovf_d   = 1'b1;
                        advance = 1'b1;
                    end else if (pos_ready_in) begin
                        advance = 1'b1;
                    end else if (wait_d == TO_LIM) begin
                        if (tcount_q != 8'hFF) begin
                            tcount_d = tcount_q + 8'd1;
                        end
                        advance = 1'b1;
                    end
                end
            end
            ST_COMMIT: begin
                // The write on the outputs this cycle lands even when aborting
                vcount_d = vcount_q + 5'd1;
                if (!playing) begin
                    abort = 1'b1;
                end else begin
                    advance = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (advance) begin
            if (idx_q == LAST_IDX) begin
                state_d = ST_DONE;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = ST_ISSUE;
            end
        end

        if (abort) begin
            state_d = ST_IDLE;
            abort_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            vcount_q <= '0;
            ovf_q    <= 1'b0;
            wait_q   <= '0;
            tcount_q <= '0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            vcount_q <= vcount_d;
            ovf_q    <= ovf_d;
            wait_q   <= wait_d;
            tcount_q <= tcount_d;
            abort_q  <= abort_d;
        end
    end

    assign idx_out           = idx_q;
    assign idx_valid_out     = (state_q == ST_ISSUE);
    assign slot_we_out       = (state_q == ST_COMMIT);
    assign slot_addr_out     = vcount_q[3:0];
    assign slot_index_out    = idx_q;
    assign visible_count_out = vcount_q;
    assign scan_busy_out     = (state_q != ST_IDLE);
    assign scan_done_out     = (state_q == ST_DONE);
    assign overflow_out      = ovf_q;
    assign timeout_count_out = tcount_q;
    assign aborted_out       = abort_q;

endmodule

// File: tb/tb_block_scan_scheduler.sv
// Bench for block_scan_scheduler: table-driven frame scans plus
// abort, re-pulse, menu and mid-commit reset sequences.
module tb_block_scan_scheduler;
    import game_pkg::*;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       new_frame_in = 1'b0;
    logic [1:0] game_state_in = GS_PLAYING;
    logic [7:0] idx_out;
    logic       idx_valid_out;
    logic       pos_ready_in = 1'b0;
    logic       pos_visible_in = 1'b0;
    logic       slot_we_out;
    logic [3:0] slot_addr_out;
    logic [7:0] slot_index_out;
    logic [4:0] visible_count_out;
    logic       scan_busy_out;
    logic       scan_done_out;
    logic       overflow_out;
    logic [7:0] timeout_count_out;
    logic       aborted_out;
    logic [3:0] raddr = 4'd0;
    logic [7:0] rdata;

    block_scan_scheduler dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .new_frame_in      (new_frame_in),
        .game_state_in     (game_state_in),
        .idx_out           (idx_out),
        .idx_valid_out     (idx_valid_out),
        .pos_ready_in      (pos_ready_in),
        .pos_visible_in    (pos_visible_in),
        .slot_we_out       (slot_we_out),
        .slot_addr_out     (slot_addr_out),
        .slot_index_out    (slot_index_out),
        .visible_count_out (visible_count_out),
        .scan_busy_out     (scan_busy_out),
        .scan_done_out     (scan_done_out),
        .overflow_out      (overflow_out),
        .timeout_count_out (timeout_count_out),
        .aborted_out       (aborted_out)
    );

    visible_slot_table tbl (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .we_in     (slot_we_out),
        .waddr_in  (slot_addr_out),
        .wdata_in  (slot_index_out),
        .raddr_in  (raddr),
        .rdata_out (rdata)
    );

    always #5 clk_in = ~clk_in;

    int compared = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] i;
    } wr_t;

    typedef struct {
        logic [7:0]      mask;
        logic            respond;
        int              done_cyc;
        int              vc;
        logic            ovf;
        int              tcnt;
        int              nwr;
        logic [3:0][7:0] wr;
    } vec_t;

    int   cyc = 0;
    int   start_cyc = 0;
    int   done_at = -1;
    int   dones = 0;
    int   aborts = 0;
    int   ivalids = 0;
    wr_t  wq[$];
    logic req_seen = 1'b0;
    logic [7:0] req_idx = 8'd0;
    logic [7:0] mask = 8'd0;
    logic respond = 1'b0;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Lookup model: answers in the first WAIT cycle after a request
    always @(posedge clk_in) begin
        #1;
        pos_ready_in   = respond && req_seen;
        pos_visible_in = mask[req_idx[2:0]];
    end

    always @(negedge clk_in) begin
        if (scan_done_out) begin
            dones++;
            done_at = cyc - start_cyc;
        end
        if (aborted_out) aborts++;
        if (idx_valid_out) ivalids++;
        if (slot_we_out) wq.push_back({slot_addr_out, slot_index_out});
        req_seen = idx_valid_out;
        req_idx  = idx_out;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        dones   = 0;
        aborts  = 0;
        ivalids = 0;
        done_at = -1;
        wq.delete();
    endtask

    task automatic start_frame();
        @(posedge clk_in); #1;
        start_cyc    = cyc;
        new_frame_in = 1'b1;
        @(posedge clk_in); #1;
        new_frame_in = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int n = 0; n < 300 && dones == 0; n++) @(negedge clk_in);
        if (dones == 0) begin
            compared++;
            mismatched++;
            $display("FAIL %s: no scan_done within 300 cycles", name);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " idx_out"}, 32'(idx_out), 0);
        chk({tag, " idx_valid"}, 32'(idx_valid_out), 0);
        chk({tag, " slot_we"}, 32'(slot_we_out), 0);
        chk({tag, " slot_addr"}, 32'(slot_addr_out), 0);
        chk({tag, " slot_index"}, 32'(slot_index_out), 0);
        chk({tag, " vcount"}, 32'(visible_count_out), 0);
        chk({tag, " busy"}, 32'(scan_busy_out), 0);
        chk({tag, " done"}, 32'(scan_done_out), 0);
        chk({tag, " overflow"}, 32'(overflow_out), 0);
        chk({tag, " tcount"}, 32'(timeout_count_out), 0);
        chk({tag, " aborted"}, 32'(aborted_out), 0);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{8'h3F, 1'b1, 17, 4, 1'b1, 0, 4, {8'd3, 8'd2, 8'd1, 8'd0}};
        vecs[1] = '{8'h12, 1'b1, 15, 2, 1'b0, 0, 2, {8'd0, 8'd0, 8'd4, 8'd1}};
        vecs[2] = '{8'h01, 1'b1, 14, 1, 1'b0, 0, 1, {8'd0, 8'd0, 8'd0, 8'd0}};
        vecs[3] = '{8'h00, 1'b1, 13, 0, 1'b0, 0, 0, {8'd0, 8'd0, 8'd0, 8'd0}};
        vecs[4] = '{8'h3F, 1'b0, 97, 0, 1'b0, 6, 0, {8'd0, 8'd0, 8'd0, 8'd0}};

        repeat (3) @(posedge clk_in);
        #1 rst_in = 1'b0;
        @(negedge clk_in);
        chk_reset_outputs("reset");

        foreach (vecs[v]) begin
            mask    = vecs[v].mask;
            respond = vecs[v].respond;
            clear_mon();
            start_frame();
            wait_done($sformatf("vec%0d", v));
            repeat (3) @(negedge clk_in);
            chk($sformatf("vec%0d done_cyc", v), 32'(done_at), 32'(vecs[v].done_cyc));
            chk($sformatf("vec%0d dones", v), 32'(dones), 1);
            chk($sformatf("vec%0d ivalids", v), 32'(ivalids), 6);
            chk($sformatf("vec%0d vcount", v), 32'(visible_count_out), 32'(vecs[v].vc));
            chk($sformatf("vec%0d overflow", v), 32'(overflow_out), 32'(vecs[v].ovf));
            chk($sformatf("vec%0d tcount", v), 32'(timeout_count_out), 32'(vecs[v].tcnt));
            chk($sformatf("vec%0d busy", v), 32'(scan_busy_out), 0);
            chk($sformatf("vec%0d nwrites", v), 32'(wq.size()), 32'(vecs[v].nwr));
            for (int k = 0; k < vecs[v].nwr && k < wq.size(); k++) begin
                chk($sformatf("vec%0d wr%0d addr", v, k), 32'(wq[k].a), 32'(k));
                chk($sformatf("vec%0d wr%0d idx", v, k), 32'(wq[k].i), 32'(vecs[v].wr[k]));
                raddr = 4'(k);
                #1;
                chk($sformatf("vec%0d tbl%0d", v, k), 32'(rdata), 32'(vecs[v].wr[k]));
            end
        end

        // Pause during WAIT of block 2; blocks 0 and 1 time out first
        mask    = 8'h3F;
        respond = 1'b0;
        clear_mon();
        start_frame();
        begin
            int n;
            for (n = 0; n < 200; n++) begin
                @(negedge clk_in);
                if (idx_valid_out && idx_out == 8'd2) break;
            end
            chk("abort reach idx2", 32'(n < 200), 1);
        end
        @(posedge clk_in); #1;
        game_state_in = GS_PAUSED;
        @(negedge clk_in);
        chk("abort wait busy", 32'(scan_busy_out), 1);
        chk("abort wait pulse", 32'(aborted_out), 0);
        @(posedge clk_in); #1;
        game_state_in = GS_PLAYING;
        @(negedge clk_in);
        chk("abort pulse", 32'(aborted_out), 1);
        chk("abort idle", 32'(scan_busy_out), 0);
        @(negedge clk_in);
        chk("abort pulse end", 32'(aborted_out), 0);
        repeat (5) @(negedge clk_in);
        chk("abort count", 32'(aborts), 1);
        chk("abort no done", 32'(dones), 0);
        chk("abort tcount", 32'(timeout_count_out), 8);
        chk("abort no writes", 32'(wq.size()), 0);

        // Frame pulse mid-scan must not restart the scan
        mask    = 8'h00;
        respond = 1'b1;
        clear_mon();
        start_frame();
        repeat (3) @(posedge clk_in);
        #1 new_frame_in = 1'b1;
        @(posedge clk_in); #1 new_frame_in = 1'b0;
        wait_done("repulse");
        repeat (20) @(negedge clk_in);
        chk("repulse done_cyc", 32'(done_at), 13);
        chk("repulse dones", 32'(dones), 1);
        chk("repulse ivalids", 32'(ivalids), 6);

        // No scan outside GS_PLAYING
        clear_mon();
        game_state_in = GS_MENU;
        start_frame();
        repeat (20) @(negedge clk_in);
        chk("menu ivalids", 32'(ivalids), 0);
        chk("menu busy", 32'(scan_busy_out), 0);
        game_state_in = GS_PLAYING;

        // Reset while block 0 is in COMMIT (cycle 3)
        mask    = 8'h3F;
        respond = 1'b1;
        clear_mon();
        start_frame();
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("rst commit we", 32'(slot_we_out), 1);
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        @(negedge clk_in);
        chk_reset_outputs("rst_commit");
        repeat (5) @(negedge clk_in);
        chk("rst no abort", 32'(aborts), 0);
        chk("rst no done", 32'(dones), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
